// File: rtl/datapath_pkg.sv
// Shared datapath types: memory-responder FSM states, request source and
// the latched request record used by dp_mem_responder.
package datapath_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_WADDR_W = MEM_ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IREQ,
    S_DREQ,
    S_RESP,
    S_HALTED
  } mem_resp_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } mem_src_t;

  typedef struct packed {
    logic [MEM_WADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0]  wdata;
    logic                   wen;
    mem_src_t               src;
  } mem_req_t;

endpackage

// File: rtl/dp_mem_responder.sv
// Arbitrates datapath instruction/data requests onto a single-port word RAM,
// returning registered one-cycle hits and quiescing into HALTED on halt.
module dp_mem_responder
  import datapath_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  input  logic              halt,
  output logic              flushed,
  output logic              ram_req,
  output logic              ram_wen,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  mem_resp_state_t   state_q;
  mem_req_t          req_q;
  mem_req_t          dreq_d;
  mem_req_t          ireq_d;
  logic              ihit_q;
  logic              dhit_q;
  logic              flushed_q;
  logic [DATA_W-1:0] imemload_q;
  logic [DATA_W-1:0] dmemload_q;

  // Byte offsets never reach the word-addressed RAM.
  logic unused_byte_offsets;
  assign unused_byte_offsets = ^{imemaddr[1:0], dmemaddr[1:0]};

  always_comb begin
    // NOTE: assign a full default first so no path through this block leaves
    // a field unassigned, which would otherwise infer a latch.
    dreq_d       = '0;
    dreq_d.addr  = MEM_WADDR_W'(dmemaddr[ADDR_W-1:2]);
    dreq_d.wdata = MEM_DATA_W'(dmemstore);
    dreq_d.wen   = dmemWEN;
    dreq_d.src   = SRC_D;

    ireq_d       = '0;
    ireq_d.addr  = MEM_WADDR_W'(imemaddr[ADDR_W-1:2]);
    ireq_d.src   = SRC_I;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      flushed_q  <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (halt) begin
            state_q   <= S_HALTED;
            flushed_q <= 1'b1;
          end else if (dmemREN || dmemWEN) begin
            req_q   <= dreq_d;
            state_q <= S_DREQ;
          end else if (imemREN) begin
            req_q   <= ireq_d;
            state_q <= S_IREQ;
          end
        end
        S_IREQ, S_DREQ: begin
          if (ram_ack) begin
            if (req_q.src == SRC_I) begin
              imemload_q <= ram_rdata;
              ihit_q     <= 1'b1;
            end else begin
              if (!req_q.wen) dmemload_q <= ram_rdata;
              dhit_q <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        // Inputs are deliberately ignored here so a held REN is not re-served.
        S_RESP: begin
          state_q   <= halt ? S_HALTED : S_IDLE;
          flushed_q <= halt;
        end
        S_HALTED: flushed_q <= 1'b1;
        default:  state_q   <= S_IDLE;
      endcase
    end
  end

  assign ram_req   = (state_q == S_IREQ) || (state_q == S_DREQ);
  assign ram_wen   = (state_q == S_DREQ) && req_q.wen;
  assign ram_addr  = req_q.addr[ADDR_W-3:0];
  assign ram_wdata = req_q.wdata[DATA_W-1:0];

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign flushed  = flushed_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Self-checking bench for dp_mem_responder: a behavioural RAM drives the
// memory side while a transaction-level model predicts hits, data and timing.
module tb_dp_mem_responder;

  logic        CLK;
  logic        rst;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        halt;
  logic        flushed;
  logic        ram_req;
  logic        ram_wen;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  bit stray_ack = 1'b0;

  // ram_mem is what the RAM holds; ref_mem is what the model believes it holds.
  logic [31:0] ram_mem [int];
  logic [31:0] ref_mem [int];
  logic [31:0] exp_iload;
  logic [31:0] exp_dload;

  dp_mem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .rst(rst),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .halt(halt), .flushed(flushed),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] dflt(int a);
    logic [31:0] aa;
    aa = 32'(a);
    return (aa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ram_rd(int a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Backing RAM: acks after ack_delay cycles of ram_req; can inject stray acks.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    ram_ack   = 1'b0;
    ram_rdata = '0;
    forever begin
      @(posedge CLK);
      #2;
      ram_ack = 1'b0;
      if (ram_req && !rst) begin
        if (wait_cnt >= ack_delay) begin
          ram_ack  = 1'b1;
          wait_cnt = 0;
          if (ram_wen) ram_mem[int'(ram_addr)] = ram_wdata;
          else         ram_rdata = ram_rd(int'(ram_addr));
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (stray_ack) begin
          ram_ack   = 1'b1;
          ram_rdata = $urandom;
        end
      end
    end
  end

  // Presents one request set (I and/or D) and checks every cycle until each
  // request has hit. Model: data beats instruction; a request seen in IDLE at
  // cycle c hits at c+2+delay, and the next IDLE is the cycle after a hit.
  task automatic run_txn(input bit i_en, input logic [31:0] ia, input bit d_ren,
                         input bit d_wen, input logic [31:0] da,
                         input logic [31:0] dd, input int dly);
    bit d_pend;
    bit i_pend;
    bit cur_d;
    int exp_hit;
    int req_start;
    d_pend    = d_ren | d_wen;
    i_pend    = i_en;
    ack_delay = dly;
    imemREN   = i_en;
    imemaddr  = ia;
    dmemREN   = d_ren;
    dmemWEN   = d_wen;
    dmemaddr  = da;
    dmemstore = dd;
    cur_d     = d_pend;
    exp_hit   = cyc + 2 + dly;
    while (d_pend || i_pend) begin
      step();
      req_start = exp_hit - 1 - dly;
      check("ram_req", ram_req, (cyc >= req_start) && (cyc < exp_hit));
      if (ram_req) begin
        check("ram_addr", ram_addr, cur_d ? da[31:2] : ia[31:2]);
        check("ram_wen", ram_wen, cur_d && d_wen);
        if (cur_d && d_wen) check("ram_wdata", ram_wdata, dd);
      end
      if (ihit || dhit || cyc >= exp_hit) begin
        check("ihit", ihit, !cur_d);
        check("dhit", dhit, cur_d);
        check("hit_cycle", cyc, exp_hit);
        if (cur_d) begin
          if (d_wen) ref_mem[int'(da[31:2])] = dd;
          else       exp_dload = ref_rd(int'(da[31:2]));
          d_pend  = 1'b0;
          dmemREN = 1'b0;
          dmemWEN = 1'b0;
        end else begin
          exp_iload = ref_rd(int'(ia[31:2]));
          i_pend    = 1'b0;
          imemREN   = 1'b0;
        end
        check("imemload", imemload, exp_iload);
        check("dmemload", dmemload, exp_dload);
        cur_d   = 1'b0;
        exp_hit = cyc + 3 + dly;
      end
    end
    repeat (3) begin
      step();
      check("no_extra_hit", {ihit, dhit}, 2'b00);
      check("idle_ram_req", ram_req, 1'b0);
    end
  endtask

  initial begin
    int s0;
    rst       = 1'b1;
    imemREN   = 1'b0;
    imemaddr  = '0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    halt      = 1'b0;
    exp_iload = '0;
    exp_dload = '0;

    step();
    step();
    check("rst_ihit", ihit, 1'b0);
    check("rst_dhit", dhit, 1'b0);
    check("rst_ram_req", ram_req, 1'b0);
    check("rst_ram_wen", ram_wen, 1'b0);
    check("rst_flushed", flushed, 1'b0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_dmemload", dmemload, 32'h0);
    check("rst_ram_addr", ram_addr, 30'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    rst = 1'b0;
    step();

    // Instruction read at 0x104 -> word 0x41, hit 3 cycles after request.
    ram_mem[32'h41] = 32'hDEAD_BEEF;
    ref_mem[32'h41] = 32'hDEAD_BEEF;
    run_txn(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1);
    check("iread_value", imemload, 32'hDEAD_BEEF);

    // Simultaneous I and D reads: data first at word 0x80, then instruction.
    run_txn(1'b1, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 0);

    // Zero-latency write; dmemload must keep the earlier read value.
    run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 0);
    check("write_ram_mem", ram_rd(32'h4), 32'h1234_5678);

    // REN and WEN together behave as a write.
    run_txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h26, 32'hCAFE_F00D, 1);

    // Instruction fetch of a word written by the prioritised data write.
    run_txn(1'b1, 32'h33, 1'b0, 1'b1, 32'h30, 32'hA5A5_1234, 2);

    // Stray acks while idle must not create hits or disturb load data.
    stray_ack = 1'b1;
    repeat (3) begin
      step();
      check("stray_hits", {ihit, dhit}, 2'b00);
      check("stray_ram_req", ram_req, 1'b0);
      check("stray_imemload", imemload, exp_iload);
      check("stray_dmemload", dmemload, exp_dload);
    end
    stray_ack = 1'b0;

    for (int n = 0; n < 24; n++) begin
      int kind;
      int dly;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] dd;
      kind = $urandom_range(0, 5);
      dly  = $urandom_range(0, 3);
      ia   = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      da   = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      dd   = $urandom;
      case (kind)
        0:       run_txn(1'b1, ia, 1'b0, 1'b0, da, dd, dly);
        1:       run_txn(1'b0, ia, 1'b1, 1'b0, da, dd, dly);
        2:       run_txn(1'b0, ia, 1'b0, 1'b1, da, dd, dly);
        3:       run_txn(1'b0, ia, 1'b1, 1'b1, da, dd, dly);
        4:       run_txn(1'b1, ia, 1'b1, 1'b0, da, dd, dly);
        default: run_txn(1'b1, ia, 1'b0, 1'b1, da, dd, dly);
      endcase
    end

    // Reset during IREQ: ram_req drops at once and the hit never appears.
    ack_delay = 10;
    imemREN   = 1'b1;
    imemaddr  = 32'h80;
    step();
    check("pre_rst_ram_req", ram_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_ram_req", ram_req, 1'b0);
    imemREN = 1'b0;
    step();
    step();
    rst       = 1'b0;
    exp_iload = '0;
    exp_dload = '0;
    check("post_rst_imemload", imemload, 32'h0);
    repeat (12) begin
      step();
      check("aborted_ihit", ihit, 1'b0);
      check("aborted_ram_req", ram_req, 1'b0);
    end
    run_txn(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 0);

    // Halt during DREQ with a 5-cycle ack: finish, then flush and stay quiet.
    ack_delay = 5;
    dmemREN   = 1'b1;
    dmemaddr  = 32'h58;
    s0        = cyc;
    step();
    check("halt_ram_req_start", ram_req, 1'b1);
    halt = 1'b1;
    while (!dhit && cyc < s0 + 20) begin
      step();
      if (!dhit) check("halt_ram_req_hold", ram_req, 1'b1);
    end
    check("halt_dhit", dhit, 1'b1);
    check("halt_hit_cycle", cyc, s0 + 7);
    check("halt_dmemload", dmemload, ref_rd(32'h16));
    dmemREN = 1'b0;
    step();
    check("halt_flushed", flushed, 1'b1);
    imemREN  = 1'b1;
    imemaddr = 32'h8;
    repeat (5) begin
      step();
      check("halted_ram_req", ram_req, 1'b0);
      check("halted_ihit", ihit, 1'b0);
      check("halted_flushed", flushed, 1'b1);
    end
    imemREN = 1'b0;
    halt    = 1'b0;
    rst     = 1'b1;
    step();
    check("halt_rst_flushed", flushed, 1'b0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
